// File: rtl/mem_access_ctrl.sv
// Load/store controller between EX and a byte-addressed big-endian data memory.
// Sub-word stores are read-modify-write because the memory only commits whole words.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// RD    | mem_read high, word captured at the closing edge
// WR    | mem_write high for one full cycle, memory commits on negedge
// RESP  | resp_valid high, outputs held until resp_ready
module mem_access_ctrl #(
   parameter int MEM_BYTES = 200,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_write,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   // one extra bit so addresses near the top of the space cannot wrap past the limit
   localparam logic [ADDR_W:0] LIMIT     = (ADDR_W+1)'(MEM_BYTES);
   localparam logic [ADDR_W:0] WORD_LAST = (ADDR_W+1)'(3);

   state_t            state;
   logic              op_write;
   logic [1:0]        op_size;
   logic              op_signed;
   logic [1:0]        op_off;
   logic [15:0]       op_wdata;

   logic [ADDR_W-1:0] addr_al;
   logic              req_err;
   logic [4:0]        lane_sh;
   logic [7:0]        rd_byte;
   logic [15:0]       rd_half;
   logic [DATA_W-1:0] load_val;
   logic [DATA_W-1:0] byte_mask;
   logic [DATA_W-1:0] merged;

   always_comb begin
      addr_al = {req_addr[ADDR_W-1:2], 2'b00};
      req_err = 1'b0;
      if (({1'b0, addr_al} + WORD_LAST) >= LIMIT) req_err = 1'b1;
      case (req_size)
         2'b01:   if (req_addr[0]) req_err = 1'b1;
         2'b10:   if (req_addr[1:0] != 2'b00) req_err = 1'b1;
         2'b11:   req_err = 1'b1;
         default: ;
      endcase
   end

   // big-endian lanes: byte offset k lives at [31-8k -: 8]
   always_comb begin
      lane_sh   = {~op_off, 3'b000};
      rd_byte   = 8'(mem_rdata >> lane_sh);
      rd_half   = op_off[1] ? mem_rdata[15:0] : mem_rdata[31:16];
      load_val  = mem_rdata;
      case (op_size)
         2'b00:   load_val = op_signed ? {{24{rd_byte[7]}}, rd_byte} : {24'b0, rd_byte};
         2'b01:   load_val = op_signed ? {{16{rd_half[15]}}, rd_half} : {16'b0, rd_half};
         default: ;
      endcase
      byte_mask = 32'h0000_00FF << lane_sh;
      merged    = (mem_rdata & ~byte_mask) | ({24'b0, op_wdata[7:0]} << lane_sh);
      if (op_size == 2'b01)
         merged = op_off[1] ? {mem_rdata[31:16], op_wdata} : {op_wdata, mem_rdata[15:0]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         req_ready  <= 1'b0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_write  <= 1'b0;
         mem_read   <= 1'b0;
         op_write   <= 1'b0;
         op_size    <= 2'b00;
         op_signed  <= 1'b0;
         op_off     <= 2'b00;
         op_wdata   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!req_ready) begin
                  req_ready <= 1'b1;
               end else if (req_valid) begin
                  req_ready <= 1'b0;
                  op_write  <= req_write;
                  op_size   <= req_size;
                  op_signed <= req_signed;
                  op_off    <= req_addr[1:0];
                  op_wdata  <= req_wdata[15:0];
                  if (req_err) begin
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                     state      <= RESP;
                  end else begin
                     mem_addr <= addr_al;
                     if (req_write && req_size == 2'b10) begin
                        mem_wdata <= req_wdata;
                        mem_write <= 1'b1;
                        state     <= WR;
                     end else begin
                        mem_read <= 1'b1;
                        state    <= RD;
                     end
                  end
               end
            end
            RD: begin
               mem_read <= 1'b0;
               if (op_write) begin
                  mem_wdata <= merged;
                  mem_write <= 1'b1;
                  state     <= WR;
               end else begin
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= load_val;
                  state      <= RESP;
               end
            end
            WR: begin
               mem_write  <= 1'b0;
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               resp_rdata <= '0;
               state      <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  resp_err   <= 1'b0;
                  resp_rdata <= '0;
                  req_ready  <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a 50-word big-endian memory model.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid, req_ready, req_write, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        mem_write, mem_read;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem [0:49];
   int          wr_cnt = 0, rd_cnt = 0, rv_cnt = 0;
   logic [31:0] last_waddr = 0, last_wdata = 0;

   typedef struct {
      string       name;
      logic        w;
      logic [1:0]  sz;
      logic        sg;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } req_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   exp_t sb_q[$];

   mem_access_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always_comb begin
      mem_rdata = 32'h0;
      if (mem_addr < 32'd200) mem_rdata = mem[mem_addr[7:2]];
   end

   always @(negedge clk) begin
      if (mem_write) begin
         wr_cnt++;
         last_waddr = mem_addr;
         last_wdata = mem_wdata;
         if (mem_addr < 32'd200) mem[mem_addr[7:2]] = mem_wdata;
      end
      if (mem_read) rd_cnt++;
      if (resp_valid) rv_cnt++;
   end

   task automatic issue(input req_t r, output int waited);
      req_valid  = 1'b1;
      req_write  = r.w;
      req_size   = r.sz;
      req_signed = r.sg;
      req_addr   = r.a;
      req_wdata  = r.d;
      waited     = 0;
      while (!req_ready && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic await_resp(output logic [31:0] rd, output logic e, output int lat);
      lat = 1;
      while (!resp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      rd = resp_rdata;
      e  = resp_err;
      if (resp_valid && resp_ready) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic run_table(input req_t t[$]);
      logic [31:0] rd;
      logic        e;
      int          lat, waited;
      exp_t        ex;
      foreach (t[i]) begin
         sb_q.push_back('{t[i].rdata, t[i].err, t[i].lat});
         issue(t[i], waited);
         await_resp(rd, e, lat);
         ex = sb_q.pop_front();
         total++;
         if (rd !== ex.rdata || e !== ex.err || lat !== ex.lat) begin
            bad++;
            $display("FAIL %s: rdata=%h err=%b lat=%0d, expected rdata=%h err=%b lat=%0d",
                     t[i].name, rd, e, lat, ex.rdata, ex.err, ex.lat);
         end
      end
   endtask

   task automatic test_reset;
      req_valid = 0; req_write = 0; req_size = 0; req_signed = 0;
      req_addr = 0; req_wdata = 0; resp_ready = 1;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({req_ready, resp_valid, resp_err, mem_write, mem_read} !== 5'b0 ||
          resp_rdata !== 0 || mem_addr !== 0 || mem_wdata !== 0) begin
         bad++;
         $display("FAIL reset_outputs: ctl=%b rdata=%h addr=%h wdata=%h, expected all zero",
                  {req_ready, resp_valid, resp_err, mem_write, mem_read}, resp_rdata, mem_addr, mem_wdata);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      total++;
      if (req_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_ready: req_ready=%b, expected 1", req_ready);
      end
   endtask

   task automatic test_load;
      req_t t[$];
      int   r0 = rd_cnt, w0 = wr_cnt;
      t.push_back('{"lw4", 0, 2'b10, 0, 32'd4, 0, 32'h0000_0014, 0, 2});
      run_table(t);
      total++;
      if (wr_cnt - w0 !== 0 || rd_cnt - r0 !== 1) begin
         bad++;
         $display("FAIL lw4_mem_activity: writes=%0d reads=%0d, expected 0 and 1", wr_cnt - w0, rd_cnt - r0);
      end
   endtask

   task automatic test_sub_store;
      req_t t[$];
      int   r0 = rd_cnt, w0 = wr_cnt;
      t.push_back('{"sb9", 1, 2'b00, 0, 32'd9, 32'h0000_00AB, 0, 0, 3});
      run_table(t);
      total++;
      if (wr_cnt - w0 !== 1 || rd_cnt - r0 !== 1 || last_waddr !== 32'd8 || last_wdata !== 32'h00AB_001E) begin
         bad++;
         $display("FAIL sb9_rmw: writes=%0d reads=%0d addr=%h wdata=%h, expected 1 1 00000008 00ab001e",
                  wr_cnt - w0, rd_cnt - r0, last_waddr, last_wdata);
      end
      t.delete();
      t.push_back('{"lw8_after_sb", 0, 2'b10, 0, 32'd8, 0, 32'h00AB_001E, 0, 2});
      run_table(t);
   endtask

   task automatic test_sign_ext;
      req_t t[$];
      t.push_back('{"sw0",       1, 2'b10, 0, 32'd0,  32'h0000_8001, 0, 0, 2});
      t.push_back('{"lh2_s",     0, 2'b01, 1, 32'd2,  0, 32'hFFFF_8001, 0, 2});
      t.push_back('{"lh2_u",     0, 2'b01, 0, 32'd2,  0, 32'h0000_8001, 0, 2});
      t.push_back('{"lb2_s",     0, 2'b00, 1, 32'd2,  0, 32'hFFFF_FF80, 0, 2});
      t.push_back('{"lb3_u",     0, 2'b00, 0, 32'd3,  0, 32'h0000_0001, 0, 2});
      t.push_back('{"lh0_s",     0, 2'b01, 1, 32'd0,  0, 32'h0000_0000, 0, 2});
      t.push_back('{"sh12",      1, 2'b01, 0, 32'd12, 32'h1234_BEEF, 0, 0, 3});
      t.push_back('{"lw12",      0, 2'b10, 0, 32'd12, 0, 32'hBEEF_0028, 0, 2});
      run_table(t);
   endtask

   task automatic test_errors;
      req_t t[$];
      int   r0 = rd_cnt, w0 = wr_cnt;
      t.push_back('{"lw6_mis",   0, 2'b10, 0, 32'd6,   0, 0, 1, 1});
      t.push_back('{"lh3_mis",   0, 2'b01, 1, 32'd3,   0, 0, 1, 1});
      t.push_back('{"size11",    0, 2'b11, 0, 32'd0,   0, 0, 1, 1});
      t.push_back('{"sw6_mis",   1, 2'b10, 0, 32'd6,   32'hDEAD_BEEF, 0, 1, 1});
      t.push_back('{"lw200_oor", 0, 2'b10, 0, 32'd200, 0, 0, 1, 1});
      t.push_back('{"sb201_oor", 1, 2'b00, 0, 32'd201, 32'h55, 0, 1, 1});
      t.push_back('{"lw_top",    0, 2'b10, 0, 32'hFFFF_FFFC, 0, 0, 1, 1});
      run_table(t);
      total++;
      if (wr_cnt != w0 || rd_cnt != r0) begin
         bad++;
         $display("FAIL err_no_access: writes=%0d reads=%0d, expected 0 0", wr_cnt - w0, rd_cnt - r0);
      end
      // 196..199 is the last whole word inside 200 bytes
      t.delete();
      t.push_back('{"sw196",     1, 2'b10, 0, 32'd196, 32'hCAFE_F00D, 0, 0, 2});
      t.push_back('{"lw196",     0, 2'b10, 0, 32'd196, 0, 32'hCAFE_F00D, 0, 2});
      t.push_back('{"lb199_u",   0, 2'b00, 0, 32'd199, 0, 32'h0000_000D, 0, 2});
      t.push_back('{"lw192",     0, 2'b10, 0, 32'd192, 0, 32'h0000_0000, 0, 2});
      run_table(t);
   endtask

   task automatic test_backpressure;
      req_t        t[$];
      req_t        r;
      logic [31:0] rd;
      logic        e;
      int          lat, waited;
      exp_t        ex;
      resp_ready = 1'b0;
      r = '{"lw4_hold", 0, 2'b10, 0, 32'd4, 0, 32'h0000_0014, 0, 2};
      sb_q.push_back('{r.rdata, r.err, r.lat});
      issue(r, waited);
      await_resp(rd, e, lat);
      ex = sb_q.pop_front();
      total++;
      if (rd !== ex.rdata || e !== ex.err || lat !== ex.lat) begin
         bad++;
         $display("FAIL lw4_hold: rdata=%h err=%b lat=%0d, expected %h %b %0d", rd, e, lat, ex.rdata, ex.err, ex.lat);
      end
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         total++;
         if (resp_valid !== 1'b1 || resp_rdata !== ex.rdata || resp_err !== 1'b0 || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL hold_cycle%0d: valid=%b rdata=%h err=%b ready=%b, expected 1 %h 0 0",
                     c, resp_valid, resp_rdata, resp_err, req_ready, ex.rdata);
         end
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      total++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         bad++;
         $display("FAIL hold_release: valid=%b ready=%b, expected 0 1", resp_valid, req_ready);
      end
      t.push_back('{"b2b_lw0",   0, 2'b10, 0, 32'd0, 0, 32'h0000_8001, 0, 2});
      t.push_back('{"b2b_lw8",   0, 2'b10, 0, 32'd8, 0, 32'h00AB_001E, 0, 2});
      t.push_back('{"b2b_lb9_u", 0, 2'b00, 0, 32'd9, 0, 32'h0000_00AB, 0, 2});
      t.push_back('{"b2b_lb9_s", 0, 2'b00, 1, 32'd9, 0, 32'hFFFF_FFAB, 0, 2});
      foreach (t[i]) begin
         sb_q.push_back('{t[i].rdata, t[i].err, t[i].lat});
         issue(t[i], waited);
         await_resp(rd, e, lat);
         ex = sb_q.pop_front();
         total++;
         if (waited !== 0 || rd !== ex.rdata || e !== ex.err || lat !== ex.lat) begin
            bad++;
            $display("FAIL %s: wait=%0d rdata=%h err=%b lat=%0d, expected wait=0 rdata=%h err=%b lat=%0d",
                     t[i].name, waited, rd, e, lat, ex.rdata, ex.err, ex.lat);
         end
      end
   endtask

   task automatic test_reset_abort;
      req_t t[$];
      req_t r;
      int   waited, rv0;
      r = '{"sb13_abort", 1, 2'b00, 0, 32'd13, 32'h0000_0055, 0, 0, 0};
      issue(r, waited);
      @(posedge clk); #1;
      total++;
      if (mem_write !== 1'b1) begin
         bad++;
         $display("FAIL abort_in_wr: mem_write=%b, expected 1", mem_write);
      end
      rv0 = rv_cnt;
      rst_n = 1'b0;
      #1;
      total++;
      if (mem_write !== 1'b0 || resp_valid !== 1'b0) begin
         bad++;
         $display("FAIL abort_drop: mem_write=%b resp_valid=%b, expected 0 0", mem_write, resp_valid);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (req_ready !== 1'b1 || rv_cnt !== rv0 || mem[3] !== 32'hBEEF_0028) begin
         bad++;
         $display("FAIL abort_after: ready=%b resp_cycles=%0d word12=%h, expected 1 0 beef0028",
                  req_ready, rv_cnt - rv0, mem[3]);
      end
      t.push_back('{"lw12_after_abort", 0, 2'b10, 0, 32'd12, 0, 32'hBEEF_0028, 0, 2});
      run_table(t);
   endtask

   initial begin
      for (int i = 0; i < 50; i++) mem[i] = 32'h0;
      mem[0] = 32'd10; mem[1] = 32'd20; mem[2] = 32'd30; mem[3] = 32'd40;
      test_reset();
      test_load();
      test_sub_store();
      test_sign_ext();
      test_errors();
      test_backpressure();
      test_reset_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
